// File: rtl/run_monitor_pkg.sv
// Shared definitions for the multi-core run monitor: FSM state encoding and
// default counter width.
package run_monitor_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

endpackage

// File: rtl/core_finish_latch.sv
// Per-core sticky completion flag plus the cycle count captured on the first
// end-of-operation pulse; later pulses never overwrite the timestamp.
module core_finish_latch
    import run_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             capture_en,
    input  logic             endop,
    input  logic [CNT_W-1:0] count,
    output logic             done,
    output logic [CNT_W-1:0] timestamp
);

    logic             done_q;
    logic [CNT_W-1:0] ts_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            ts_q   <= '0;
        end else if (clear) begin
            done_q <= 1'b0;
            ts_q   <= '0;
        end else if (capture_en && endop && !done_q) begin
            done_q <= 1'b1;
            ts_q   <= count;
        end
    end

    assign done      = done_q;
    assign timestamp = ts_q;

endmodule

// File: rtl/multicore_run_monitor.sv
// Launches a multi-core run, timestamps each core's completion and raises an
// all-core done handshake. Optional watchdog timeout enabled by WATCHDOG_EN.
module multicore_run_monitor
    import run_monitor_pkg::*;
#(
    parameter int               core_count    = 4,
    parameter int               CNT_W         = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(16'hFFF0)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_req,
    input  logic                        abort,
    input  logic [core_count-1:0]       endop_signal,
    output logic                        start,
    output logic                        busy,
    output logic                        done_pulse,
    output logic                        all_done,
    output logic                        timeout,
    output logic [core_count-1:0]       core_done_mask,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [core_count*CNT_W-1:0] finish_times
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, busy_q, done_pulse_q, all_done_q, timeout_q;
    logic                  start_d, busy_d, done_pulse_d, all_done_d, timeout_d;
    logic [core_count-1:0] mask_q;
    logic [core_count-1:0] mask_next;
    logic                  clear;
    logic                  capture_en;
    logic                  all_set;
    logic                  limit_hit;

    // Abort suppresses capture so the mask seen in IDLE is the pre-abort one.
    assign capture_en = (state_q == ST_RUN) && !abort;
    assign mask_next  = mask_q | (endop_signal & {core_count{capture_en}});
    assign all_set    = &mask_next;
    assign limit_hit  = (cnt_q == TIMEOUT_LIMIT);
    assign clear      = (state_d == ST_LAUNCH);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start_req) state_d = ST_LAUNCH;
                ST_LAUNCH: state_d = ST_RUN;
                ST_RUN: begin
                    if (all_set) begin
                        state_d = ST_DONE;
                    end else if (WD_EN && limit_hit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_DONE:   if (start_req) state_d = ST_LAUNCH;
`ifdef WATCHDOG_EN
                ST_TIMEOUT: if (start_req) state_d = ST_LAUNCH;
`endif
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_LAUNCH) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN && !abort && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        start_d      = (state_d == ST_LAUNCH);
        busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        all_done_d   = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            all_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
            all_done_q   <= all_done_d;
            timeout_q    <= timeout_d;
        end
    end

    for (genvar g = 0; g < core_count; g++) begin : g_core
        core_finish_latch #(
            .CNT_W(CNT_W)
        ) u_latch (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .capture_en (capture_en),
            .endop      (endop_signal[g]),
            .count      (cnt_q),
            .done       (mask_q[g]),
            .timestamp  (finish_times[g*CNT_W +: CNT_W])
        );
    end

    assign start          = start_q;
    assign busy           = busy_q;
    assign done_pulse     = done_pulse_q;
    assign all_done       = all_done_q;
    assign timeout        = timeout_q;
    assign core_done_mask = mask_q;
    assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_multicore_run_monitor.sv
// Directed bench for multicore_run_monitor: vector table for the main flows,
// hand sequences for async reset, saturation/watchdog and bounded completion.
module tb_multicore_run_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_req;
    logic        abort;
    logic [3:0]  endop_signal;
    logic        start, busy, done_pulse, all_done, timeout;
    logic [3:0]  core_done_mask;
    logic [15:0] cycle_count;
    logic [63:0] finish_times;

    logic [1:0]  sat_endop;
    logic        sat_start, sat_busy, sat_done_pulse, sat_all_done, sat_timeout;
    logic [1:0]  sat_mask;
    logic [2:0]  sat_count;
    logic [5:0]  sat_ft;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicore_run_monitor #(
        .core_count(4), .CNT_W(16), .TIMEOUT_LIMIT(16'd20)
    ) dut (
        .clk(clk), .reset(reset), .start_req(start_req), .abort(abort),
        .endop_signal(endop_signal), .start(start), .busy(busy),
        .done_pulse(done_pulse), .all_done(all_done), .timeout(timeout),
        .core_done_mask(core_done_mask), .cycle_count(cycle_count),
        .finish_times(finish_times)
    );

    multicore_run_monitor #(
        .core_count(2), .CNT_W(3), .TIMEOUT_LIMIT(3'd7)
    ) u_sat (
        .clk(clk), .reset(reset), .start_req(start_req), .abort(abort),
        .endop_signal(sat_endop), .start(sat_start), .busy(sat_busy),
        .done_pulse(sat_done_pulse), .all_done(sat_all_done), .timeout(sat_timeout),
        .core_done_mask(sat_mask), .cycle_count(sat_count),
        .finish_times(sat_ft)
    );

    typedef struct {
        logic        sr;
        logic        ab;
        logic [3:0]  en;
        int          n;
        logic        est;
        logic        ebz;
        logic        edp;
        logic        ead;
        logic [3:0]  em;
        logic [15:0] ec;
        logic [63:0] eft;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] ft4(input int t3, input int t2, input int t1, input int t0);
        return {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    endfunction

    function automatic vec_t mk(input logic sr, input logic ab, input logic [3:0] en, input int n,
                                input logic est, input logic ebz, input logic edp, input logic ead,
                                input logic [3:0] em, input int ec, input logic [63:0] eft);
        vec_t v;
        v.sr = sr; v.ab = ab; v.en = en; v.n = n;
        v.est = est; v.ebz = ebz; v.edp = edp; v.ead = ead;
        v.em = em; v.ec = 16'(ec); v.eft = eft;
        return v;
    endfunction

    initial begin
        int waited;

        //               sr    ab    endop    n  st    bz    dp    ad    mask     cnt  finish_times
        vecs[0]  = mk(1'b0, 1'b0, 4'b1111, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[1]  = mk(1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[3]  = mk(1'b0, 1'b0, 4'b0000, 5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  5, ft4(0, 0, 0, 0));
        vecs[4]  = mk(1'b0, 1'b0, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001,  6, ft4(0, 0, 0, 5));
        vecs[5]  = mk(1'b0, 1'b0, 4'b0000, 3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001,  9, ft4(0, 0, 0, 5));
        vecs[6]  = mk(1'b0, 1'b0, 4'b0100, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 10, ft4(0, 9, 0, 5));
        vecs[7]  = mk(1'b0, 1'b0, 4'b0000, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 12, ft4(0, 9, 0, 5));
        vecs[8]  = mk(1'b0, 1'b0, 4'b1010, 1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 13, ft4(12, 9, 12, 5));
        vecs[9]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 13, ft4(12, 9, 12, 5));
        vecs[10] = mk(1'b0, 1'b0, 4'b1111, 3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 13, ft4(12, 9, 12, 5));
        vecs[11] = mk(1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[12] = mk(1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[13] = mk(1'b0, 1'b0, 4'b0000, 3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  3, ft4(0, 0, 0, 0));
        vecs[14] = mk(1'b0, 1'b0, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001,  4, ft4(0, 0, 0, 3));
        vecs[15] = mk(1'b0, 1'b0, 4'b0000, 3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001,  7, ft4(0, 0, 0, 3));
        vecs[16] = mk(1'b0, 1'b0, 4'b0001, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001,  8, ft4(0, 0, 0, 3));
        vecs[17] = mk(1'b0, 1'b0, 4'b0000, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 10, ft4(0, 0, 0, 3));
        vecs[18] = mk(1'b0, 1'b0, 4'b1110, 1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 11, ft4(10, 10, 10, 3));
        vecs[19] = mk(1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[20] = mk(1'b1, 1'b0, 4'b0000, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  0, ft4(0, 0, 0, 0));
        vecs[21] = mk(1'b0, 1'b0, 4'b0000, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  2, ft4(0, 0, 0, 0));
        vecs[22] = mk(1'b0, 1'b0, 4'b0111, 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111,  3, ft4(0, 2, 2, 2));
        vecs[23] = mk(1'b0, 1'b1, 4'b1000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111,  3, ft4(0, 2, 2, 2));
        vecs[24] = mk(1'b0, 1'b0, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111,  3, ft4(0, 2, 2, 2));
        vecs[25] = mk(1'b0, 1'b0, 4'b1111, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111,  3, ft4(0, 2, 2, 2));
        vecs[26] = mk(1'b1, 1'b1, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111,  3, ft4(0, 2, 2, 2));

        reset        = 1'b0;
        start_req    = 1'b0;
        abort        = 1'b0;
        endop_signal = 4'b0000;
        sat_endop    = 2'b00;
        #12;
        check("reset busy",  64'(busy),           64'd0);
        check("reset mask",  64'(core_done_mask), 64'd0);
        check("reset count", 64'(cycle_count),    64'd0);
        check("reset ft",    finish_times,        64'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start_req    = vecs[i].sr;
            abort        = vecs[i].ab;
            endop_signal = vecs[i].en;
            tick(vecs[i].n);
            check($sformatf("v%0d start", i),      64'(start),          64'(vecs[i].est));
            check($sformatf("v%0d busy", i),       64'(busy),           64'(vecs[i].ebz));
            check($sformatf("v%0d done_pulse", i), 64'(done_pulse),     64'(vecs[i].edp));
            check($sformatf("v%0d all_done", i),   64'(all_done),       64'(vecs[i].ead));
            check($sformatf("v%0d timeout", i),    64'(timeout),        64'd0);
            check($sformatf("v%0d mask", i),       64'(core_done_mask), 64'(vecs[i].em));
            check($sformatf("v%0d count", i),      64'(cycle_count),    64'(vecs[i].ec));
            check($sformatf("v%0d ft", i),         finish_times,        vecs[i].eft);
        end
        start_req    = 1'b0;
        abort        = 1'b0;
        endop_signal = 4'b0000;

        // Only core 0 finishes: watchdog build times out, default build keeps running.
        start_req = 1'b1;
        tick(1);
        check("wd launch start", 64'(start), 64'd1);
        start_req = 1'b0;
        tick(1);
        endop_signal = 4'b0001;
        tick(1);
        endop_signal = 4'b0000;
        check("wd mask core0", 64'(core_done_mask), 64'h1);
        tick(25);
        check("wd mask held", 64'(core_done_mask), 64'h1);
        check("wd no done",   64'(all_done),       64'd0);
        check("sat count",    64'(sat_count),      64'd7);
`ifdef WATCHDOG_EN
        check("wd timeout",     64'(timeout),     64'd1);
        check("wd busy",        64'(busy),        64'd0);
        check("wd count",       64'(cycle_count), 64'd21);
        check("sat timeout",    64'(sat_timeout), 64'd1);
        check("sat busy",       64'(sat_busy),    64'd0);
`else
        check("wd timeout",     64'(timeout),     64'd0);
        check("wd busy",        64'(busy),        64'd1);
        check("wd count",       64'(cycle_count), 64'd26);
        check("sat timeout",    64'(sat_timeout), 64'd0);
        check("sat busy",       64'(sat_busy),    64'd1);
`endif
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
`ifdef WATCHDOG_EN
        check("wd relaunch start", 64'(start),          64'd1);
        check("wd relaunch mask",  64'(core_done_mask), 64'd0);
        check("wd relaunch count", 64'(cycle_count),    64'd0);
`else
        check("wd relaunch start", 64'(start),          64'd0);
        check("wd relaunch mask",  64'(core_done_mask), 64'h1);
`endif
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("wd abort busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a run, applied between clock edges.
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(3);
        endop_signal = 4'b0011;
        tick(1);
        endop_signal = 4'b0000;
        check("ar pre mask", 64'(core_done_mask), 64'h3);
        check("ar pre ft",   finish_times,        ft4(0, 0, 2, 2));
        #2;
        reset = 1'b0;
        #1;
        check("ar busy",  64'(busy),           64'd0);
        check("ar mask",  64'(core_done_mask), 64'd0);
        check("ar count", 64'(cycle_count),    64'd0);
        check("ar ft",    finish_times,        64'd0);
        #10;
        reset = 1'b1;
        tick(2);
        check("ar idle busy", 64'(busy), 64'd0);

        // All cores finish in the first RUN cycle; wait for all_done with a budget.
        endop_signal = 4'b1111;
        start_req    = 1'b1;
        tick(1);
        start_req = 1'b0;
        waited    = 0;
        while (!all_done && waited < 10) begin
            tick(1);
            waited++;
        end
        check("bw all_done",   64'(all_done),       64'd1);
        check("bw latency",    64'(waited),         64'd2);
        check("bw done_pulse", 64'(done_pulse),     64'd1);
        check("bw mask",       64'(core_done_mask), 64'hF);
        check("bw ft",         finish_times,        64'd0);
        endop_signal = 4'b0000;
        tick(1);
        check("bw pulse once", 64'(done_pulse), 64'd0);
        check("bw level held", 64'(all_done),   64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
